// File: rtl/uart_data_transmit.sv
// UART transmit engine: start bit, D7..D0, even parity, stop bit, with a one-byte holding
// register so the next byte can be queued while a frame is on the line.
module uart_data_transmit #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_EN,
    input  logic       Tx_sample_ENABLE,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_READY,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            txd_q, txd_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            bit_end;
    logic            load;
    logic [2:0]      bit_m1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txd_d       = txd_q;
        done_d      = 1'b0;
        load        = 1'b0;
        bit_end     = Tx_sample_ENABLE && (cnt_q == CntMax);
        bit_m1      = bit_q - 3'd1;

        if (Tx_sample_ENABLE && (state_q != StIdle)) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        // ready_q already implies an empty holding register, so this never races a load
        if (Tx_WR && ready_q && Tx_EN) begin
            hold_d      = Tx_DATA;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (Tx_sample_ENABLE && hold_full_q) load = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd7;
                    txd_d   = shift_q[7];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = StParity;
                        txd_d   = parity_q;
                    end else begin
                        bit_d = bit_m1;
                        txd_d = shift_q[bit_m1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (hold_full_q) load = 1'b1;
                    else             state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d     = hold_q;
            parity_d    = ^hold_q;
            hold_full_d = 1'b0;
            state_d     = StStart;
            cnt_d       = '0;
            txd_d       = 1'b0;
        end

        // Disabling flushes everything; the interrupted frame is simply dropped
        if (!Tx_EN) begin
            state_d     = StIdle;
            cnt_d       = '0;
            bit_d       = 3'd0;
            hold_full_d = 1'b0;
            txd_d       = 1'b1;
            done_d      = 1'b0;
        end

        ready_d = Tx_EN && !hold_full_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign TxD      = txd_q;
    assign Tx_READY = ready_q;
    assign Tx_BUSY  = (state_q != StIdle);
    assign Tx_DONE  = done_q;

endmodule

// File: tb/tb_uart_data_transmit.sv
// Bench for uart_data_transmit: bytes written are queued as expected frames; a line monitor
// rebuilds each frame from TxD sampled once per tick and checks it against the queue.
module tb_uart_data_transmit;
    localparam int OS         = 16;
    localparam int FrameTicks = 11 * OS;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tx_EN;
    logic       Tx_sample_ENABLE;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_READY;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    uart_data_transmit #(.OVERSAMPLE(OS)) dut (
        .clk              (clk),
        .reset            (reset),
        .Tx_EN            (Tx_EN),
        .Tx_sample_ENABLE (Tx_sample_ENABLE),
        .Tx_WR            (Tx_WR),
        .Tx_DATA          (Tx_DATA),
        .TxD              (TxD),
        .Tx_READY         (Tx_READY),
        .Tx_BUSY          (Tx_BUSY),
        .Tx_DONE          (Tx_DONE)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         n_expected = 0;
    int         done_cnt = 0;
    int         mon_frames = 0;
    int         mon_nsamp = 0;
    int         mon_gap = 0;
    int         mon_last_gap = -1;
    logic       mon_in_frame = 1'b0;
    logic       done_due = 1'b0;
    logic       samp[0:FrameTicks-1];
    logic       tick_cont = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference decode: each of the 11 bit periods is OS identical tick samples
    task automatic check_frame();
        int         glitches = 0;
        logic [7:0] d;
        logic [7:0] e;
        for (int b = 0; b < 11; b++)
            for (int k = 1; k < OS; k++)
                if (samp[b*OS+k] != samp[b*OS]) glitches++;
        for (int i = 0; i < 8; i++) d[7-i] = samp[(i+1)*OS];
        mon_frames++;
        chk("bit_levels_stable", glitches, 0);
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(d), -1);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", int'(d), int'(e));
            chk("frame_parity", int'(samp[9*OS]), $countones(e) % 2);
            chk("frame_stop", int'(samp[10*OS]), 1);
        end
    endtask

    initial begin
        Tx_sample_ENABLE = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            Tx_sample_ENABLE = tick_cont ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    // Line monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset || !Tx_EN) begin
                mon_in_frame = 1'b0;
                mon_nsamp    = 0;
                mon_gap      = 0;
                done_due     = 1'b0;
            end else begin
                if (Tx_DONE) done_cnt++;
                if (done_due) begin
                    chk("done_at_frame_end", int'(Tx_DONE), 1);
                    done_due = 1'b0;
                end
                if (Tx_sample_ENABLE) begin
                    if (!mon_in_frame && TxD == 1'b0) begin
                        mon_in_frame = 1'b1;
                        mon_nsamp    = 0;
                        mon_last_gap = mon_gap;
                    end
                    if (mon_in_frame) begin
                        samp[mon_nsamp] = TxD;
                        mon_nsamp++;
                        if (mon_nsamp == FrameTicks) begin
                            check_frame();
                            mon_in_frame = 1'b0;
                            mon_gap      = 0;
                            done_due     = 1'b1;
                        end
                    end else begin
                        mon_gap++;
                    end
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!Tx_READY && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, int'(Tx_READY), 1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready("ready_before_write");
        if (Tx_READY) begin
            Tx_WR   = 1'b1;
            Tx_DATA = b;
            exp_q.push_back(b);
            n_expected++;
            @(posedge clk);
            #1;
            Tx_WR = 1'b0;
            chk("ready_drops_after_write", int'(Tx_READY), 0);
        end
    endtask

    task automatic wait_samples(input int n);
        int c = 0;
        while (!(mon_in_frame && mon_nsamp >= n) && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("reached_frame_point", int'(mon_in_frame && mon_nsamp >= n), 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_q.size() != 0 || Tx_BUSY || mon_in_frame) && c < 10000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drained_to_idle", int'(exp_q.size() == 0 && !Tx_BUSY), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int d0;
        reset   = 1'b1;
        Tx_EN   = 1'b0;
        Tx_WR   = 1'b0;
        Tx_DATA = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", int'(TxD), 1);
        chk("reset_ready", int'(Tx_READY), 0);
        chk("reset_busy", int'(Tx_BUSY), 0);
        chk("reset_done", int'(Tx_DONE), 0);
        Tx_EN = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_held_in_reset", int'(Tx_READY), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(Tx_READY), 1);

        // Single frame, then confirm Tx_BUSY falls with the Tx_DONE pulse
        send(8'hA5);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!Tx_DONE && c < 5000);
        chk("a5_done_seen", int'(Tx_DONE), 1);
        chk("busy_falls_with_done", int'(Tx_BUSY), 0);
        @(posedge clk);
        #1;
        wait_idle();

        send(8'h07);
        wait_idle();

        // Back-to-back: second byte queued during the first frame's data bits
        d0 = done_cnt;
        send(8'h01);
        wait_ready("ready_after_load");
        wait_samples(40);
        chk("busy_mid_frame", int'(Tx_BUSY), 1);
        send(8'h80);
        wait_idle();
        chk("back_to_back_gap_ticks", mon_last_gap, 0);
        chk("back_to_back_done_pulses", done_cnt - d0, 2);

        // Write while holding register full is dropped
        send(8'h11);
        wait_ready("ready_after_load_2");
        send(8'h3C);
        Tx_WR   = 1'b1;
        Tx_DATA = 8'hFF;
        @(posedge clk);
        #1;
        Tx_WR = 1'b0;
        wait_idle();

        // Abort in the 4th data bit
        send(8'h55);
        wait_samples(70);
        Tx_EN = 1'b0;
        void'(exp_q.pop_front());
        n_expected--;
        @(posedge clk);
        @(negedge clk);
        chk("abort_txd", int'(TxD), 1);
        chk("abort_busy", int'(Tx_BUSY), 0);
        chk("abort_ready", int'(Tx_READY), 0);
        chk("abort_done", int'(Tx_DONE), 0);
        repeat (3) @(posedge clk);
        #1;
        Tx_EN = 1'b1;
        @(posedge clk);
        #1;
        send(8'h55);
        wait_idle();

        // Asynchronous reset during the parity bit
        send(8'h9A);
        wait_samples(150);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_txd", int'(TxD), 1);
        chk("async_reset_ready", int'(Tx_READY), 0);
        chk("async_reset_busy", int'(Tx_BUSY), 0);
        void'(exp_q.pop_front());
        n_expected--;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'hC3);
        wait_idle();

        // Random bytes with a continuous tick
        tick_cont = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 300)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        chk("frames_seen", mon_frames, n_expected);
        chk("done_pulses_total", done_cnt, n_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_data_transmit.md
Name: uart_data_transmit

Overview:
- UART transmit engine; counterpart of the team's receiver. Serialises one byte per frame onto TxD.
- Frame order: start bit (0), data bits D7 first down to D0, one even-parity bit, one stop bit (1).
- Bit timing is driven by the shared oversampling enable; each bit lasts OVERSAMPLE enable ticks.
- A one-entry holding register lets the host queue the next byte while the current frame is being sent.

Parameters:
OVERSAMPLE, 16, Tx_sample_ENABLE ticks per bit; legal range 2..256.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  reset, asynchronous, active-high.
Tx_EN  input  1  transmitter enable; low = idle line and flush all state.
Tx_sample_ENABLE  input  1  single-clk oversampling strobe from baud generator.
Tx_WR  input  1  write strobe; accepted only when Tx_READY=1 and Tx_EN=1.
Tx_DATA  input  8  byte to send; sampled on an accepted Tx_WR.
TxD  output  1  serial line, registered, idle high.
Tx_READY  output  1  holding register empty and a write can be accepted.
Tx_BUSY  output  1  frame in progress (state != IDLE).
Tx_DONE  output  1  one-clk pulse when a stop bit completes.

Behaviour:
- Reset values: TxD=1, Tx_READY=0, Tx_BUSY=0, Tx_DONE=0; state IDLE; holding empty; tick and bit counters 0.
- After reset release, Tx_READY = Tx_EN && holding empty (registered; valid from the first clk after reset).
- Write: Tx_WR=1 with Tx_READY=1 loads Tx_DATA into the holding register. Tx_READY drops on the next clk. A Tx_WR while Tx_READY=0 is ignored, with no error flag.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TxD=1. On a tick with the holding register full:
  - move the holding byte to the shift register;
  - compute parity = XOR of the 8 data bits, so the ones count over data plus parity is even;
  - empty the holding register (Tx_READY=1 on the next clk);
  - enter START, with the tick counter cleared.
- Tick counter: increments only on Tx_sample_ENABLE. When it equals OVERSAMPLE-1 and a tick occurs, it wraps to 0 and the current bit ends.
- START: TxD=0 for OVERSAMPLE ticks, then go to DATA with bit index 7.
- DATA: TxD = shift[bit index] for OVERSAMPLE ticks per bit. The index decrements from 7 to 0; after bit 0, go to PARITY.
- PARITY: TxD = parity for OVERSAMPLE ticks, then go to STOP.
- STOP: TxD=1 for OVERSAMPLE ticks. At the end:
  - Tx_DONE=1 for exactly one clk;
  - if the holding register is full, load it and enter START on that same tick (no idle gap);
  - otherwise enter IDLE.
- Frame length: exactly 11*OVERSAMPLE ticks, from TxD falling to the end of the stop bit.
- TxD changes only on the clk edge following a tick that ends a bit, or on the IDLE→START load edge. Line level is glitch-free.
- Tx_BUSY=1 in all states except IDLE.
- Simultaneous load and write in the same clk: the write is ignored, because Tx_READY was 0 at that time.
- Tx_EN=0 takes effect at the next clk:
  - state IDLE, TxD=1, holding emptied, counters cleared;
  - Tx_READY=0, Tx_BUSY=0, no Tx_DONE;
  - the aborted frame is truncated and not resumed.
- Reset asserted mid-frame: the outputs go to their reset values immediately (asynchronously); the frame is lost.
- Tx_sample_ENABLE held high continuously is legal: one tick per clk.

Test Plan:
- Single frame: OVERSAMPLE=16, write 0xA5 → TxD per bit period = 0,1,0,1,0,0,1,0,1,0,1 (parity 0, ones=4). Each level lasts 16 ticks; Tx_DONE pulses once at 176 ticks; Tx_BUSY falls on the same edge.
- Odd parity data: write 0x07 → data bits 0,0,0,0,0,1,1,1; parity bit 1; stop 1.
- Back-to-back: write 0x01, then write 0x80 during the first frame's DATA state:
  - Tx_READY goes 0→1 at the first load, and 0 after the second write;
  - the second start bit begins on the tick immediately after the first stop bit;
  - 22*16 ticks total with no idle gap;
  - two Tx_DONE pulses.
- Write while full: with a frame in progress and the holding register full, pulse Tx_WR with 0xFF → ignored; the queued byte (e.g. 0x3C) is transmitted next, and no 0xFF frame appears.
- Abort and reset: deassert Tx_EN in the 4th data bit of 0x55 → TxD=1 next clk, Tx_BUSY=0, no Tx_DONE. Re-enable and write 0x55 → a full correct frame. Separately, assert reset mid-PARITY → TxD=1 and Tx_READY=0 immediately.
- Loopback: TxD connected to the team receiver (same OVERSAMPLE=16 enable), send 0x3C and 0xC3 → the receiver reports Rx_DATA matching each byte, Rx_VALID=1, Rx_PERROR=0, Rx_FERROR=0.
